// File: rtl/qpi_line_pkg.sv
// Shared state encoding, index-width helper and address-step default for the
// QPI cache-line burst engine and its downstream adapter.
package qpi_line_pkg;

    // QPI word-address increment per data word, shared with the adapter.
    localparam int unsigned QPI_ADDR_STEP = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPrefetch,
        StBurst,
        StDrain
    } line_state_e;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/qpi_line_idx_ctr.sv
// Word counter, wrapped line index, last-word flag and QPI address stepping.
// QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN starts at the critical word and wraps to the line base.
module qpi_line_idx_ctr
    import qpi_line_pkg::*;
#(
    parameter int unsigned AW         = 24,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_STEP  = QPI_ADDR_STEP,
    localparam int unsigned IW        = idx_width(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic          step_i,
    output logic [IW-1:0] start_idx_o,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] next_idx_o,
    output logic          last_o,
    output logic [AW-1:0] addr_o
);

    localparam logic [AW-1:0] StepW   = AW'(ADDR_STEP);
    localparam logic [AW-1:0] SpanW   = AW'(LINE_WORDS * ADDR_STEP);
    localparam logic [IW-1:0] LastIdx = IW'(LINE_WORDS - 1);

    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] start_q, start_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] line_base;
    logic [AW-1:0] load_addr;

    assign line_base = req_addr_i - (req_addr_i % SpanW);

`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
    logic [AW-1:0] base_q, base_d;
    assign start_idx_o = IW'((req_addr_i / StepW) % AW'(LINE_WORDS));
    assign load_addr   = req_addr_i;
`else
    assign start_idx_o = '0;
    assign load_addr   = line_base;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        start_d = start_q;
        addr_d  = addr_q;
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
        base_d  = base_q;
`endif
        if (load_i) begin
            cnt_d   = '0;
            start_d = start_idx_o;
            addr_d  = load_addr;
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
            base_d  = line_base;
`endif
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
            // Wrapped burst: leaving the top word of the line returns to its base.
            addr_d = (idx_o == LastIdx) ? base_q : addr_q + StepW;
`else
            addr_d = addr_q + StepW;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            start_q <= '0;
            addr_q  <= '0;
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
            base_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            start_q <= start_d;
            addr_q  <= addr_d;
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
            base_q  <= base_d;
`endif
        end
    end

    // LINE_WORDS is a power of two, so IW-bit arithmetic wraps modulo the line.
    assign idx_o      = start_q + cnt_q;
    assign next_idx_o = idx_o + 1'b1;
    assign last_o     = (cnt_q == LastIdx);
    assign addr_o     = addr_q;

endmodule

// File: rtl/qpi_line_engine.sv
// Cache-line fill/writeback burst sequencer feeding the QPI-to-SDRAM adapter.
// Optional QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN: critical-word-first wrapped bursts.
module qpi_line_engine
    import qpi_line_pkg::*;
#(
    parameter int unsigned AW         = 24,
    parameter int unsigned DW         = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_STEP  = QPI_ADDR_STEP,
    localparam int unsigned IW        = idx_width(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    output logic          req_done,
    output logic          fill_valid,
    output logic [IW-1:0] fill_idx,
    output logic [DW-1:0] fill_data,
    output logic          wb_rd_en,
    output logic [IW-1:0] wb_rd_idx,
    input  logic [DW-1:0] wb_rd_data,
    output logic          qpi_do_read,
    output logic          qpi_do_write,
    output logic [AW-1:0] qpi_addr,
    output logic [DW-1:0] qpi_wdata,
    input  logic [DW-1:0] qpi_rdata,
    input  logic          qpi_next_word,
    input  logic          qpi_is_idle
);

    line_state_e   state_q, state_d;
    logic          write_q, write_d;
    logic          wb_pending_q, wb_pending_d;
    logic          fill_valid_q, fill_valid_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [DW-1:0] fill_data_q, fill_data_d;
    logic          req_done_q, req_done_d;
    logic [DW-1:0] qpi_wdata_q, qpi_wdata_d;

    logic          accept;
    logic          step;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] idx;
    logic [IW-1:0] next_idx;
    logic          last;
    logic          in_burst;

    assign in_burst  = (state_q == StBurst);
    assign req_ready = !rst && (state_q == StIdle) && qpi_is_idle;
    assign accept    = req_valid && req_ready;
    assign step      = in_burst && qpi_next_word;

    qpi_line_idx_ctr #(
        .AW         (AW),
        .LINE_WORDS (LINE_WORDS),
        .ADDR_STEP  (ADDR_STEP)
    ) u_idx_ctr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .req_addr_i  (req_addr),
        .step_i      (step),
        .start_idx_o (start_idx),
        .idx_o       (idx),
        .next_idx_o  (next_idx),
        .last_o      (last),
        .addr_o      (qpi_addr)
    );

    // RAM reads: first word at accept, the rest one strobe ahead of the adapter.
    assign wb_rd_en  = (accept && req_write) || (step && write_q && !last);
    assign wb_rd_idx = !wb_rd_en ? '0 : (state_q == StIdle) ? start_idx : next_idx;

    // Dropping do_x with the final strobe tells the adapter to close the burst.
    assign qpi_do_read  = in_burst && !write_q && !(qpi_next_word && last);
    assign qpi_do_write = in_burst && write_q && !(qpi_next_word && last);

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        wb_pending_d = 1'b0;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        req_done_d   = 1'b0;
        qpi_wdata_d  = qpi_wdata_q;

        if (wb_pending_q) begin
            qpi_wdata_d = wb_rd_data;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    state_d = req_write ? StPrefetch : StBurst;
                end
            end
            StPrefetch: begin
                qpi_wdata_d = wb_rd_data;
                state_d     = StBurst;
            end
            StBurst: begin
                if (step) begin
                    if (write_q) begin
                        wb_pending_d = !last;
                    end else begin
                        fill_valid_d = 1'b1;
                        fill_idx_d   = idx;
                        fill_data_d  = qpi_rdata;
                    end
                    if (last) begin
                        req_done_d = 1'b1;
                        state_d    = StDrain;
                    end
                end
            end
            StDrain: begin
                if (qpi_is_idle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            wb_pending_q <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            req_done_q   <= 1'b0;
            qpi_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            wb_pending_q <= wb_pending_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            req_done_q   <= req_done_d;
            qpi_wdata_q  <= qpi_wdata_d;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_idx   = fill_idx_q;
    assign fill_data  = fill_data_q;
    assign req_done   = req_done_q;
    assign qpi_wdata  = qpi_wdata_q;

endmodule

// File: tb/tb_qpi_line_engine.sv
// Self-checking bench for qpi_line_engine: a scripted adapter plus a fill/done scoreboard.
// Honours QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN when the RTL is built with it.
module tb_qpi_line_engine;

    localparam int unsigned AW   = 24;
    localparam int unsigned DW   = 32;
    localparam int unsigned LW   = 8;
    localparam int unsigned STEP = 2;
    localparam int unsigned IW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          req_done;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          wb_rd_en;
    logic [IW-1:0] wb_rd_idx;
    logic [DW-1:0] wb_rd_data;
    logic          qpi_do_read;
    logic          qpi_do_write;
    logic [AW-1:0] qpi_addr;
    logic [DW-1:0] qpi_wdata;
    logic [DW-1:0] qpi_rdata;
    logic          qpi_next_word;
    logic          qpi_is_idle;

    always #5 clk = ~clk;

    qpi_line_engine #(
        .AW         (AW),
        .DW         (DW),
        .LINE_WORDS (LW),
        .ADDR_STEP  (STEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .fill_valid    (fill_valid),
        .fill_idx      (fill_idx),
        .fill_data     (fill_data),
        .wb_rd_en      (wb_rd_en),
        .wb_rd_idx     (wb_rd_idx),
        .wb_rd_data    (wb_rd_data),
        .qpi_do_read   (qpi_do_read),
        .qpi_do_write  (qpi_do_write),
        .qpi_addr      (qpi_addr),
        .qpi_wdata     (qpi_wdata),
        .qpi_rdata     (qpi_rdata),
        .qpi_next_word (qpi_next_word),
        .qpi_is_idle   (qpi_is_idle)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } fill_t;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   cyc = 0;
    int unsigned   wb_rd_cnt = 0;
    fill_t         fill_q[$];
    int unsigned   done_q[$];
    fill_t         mon_e;
    logic [AW-1:0] last_addr = '0;

    logic [DW-1:0] ram [LW];
    logic [DW-1:0] ram_q = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wb_rd_en) ram_q <= ram[wb_rd_idx];
    end
    assign wb_rd_data = ram_q;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard side: pop expected fill words and done cycles as the DUT produces them.
    always @(negedge clk) begin
        if (fill_valid) begin
            if (fill_q.size() == 0) begin
                check_eq("fill_unexpected", 1, 0);
            end else begin
                mon_e = fill_q.pop_front();
                check_eq("fill_idx", fill_idx, mon_e.idx);
                check_eq("fill_data", fill_data, mon_e.data);
            end
        end
        if (req_done) begin
            if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else check_eq("done_cycle", cyc, done_q.pop_front());
        end
        if (wb_rd_en) wb_rd_cnt++;
    end

    task automatic check_reset_outputs();
        check_eq("rst_ctrl", {req_ready, req_done, fill_valid, wb_rd_en, qpi_do_read,
                              qpi_do_write}, 0);
        check_eq("rst_idx", {fill_idx, wb_rd_idx}, 0);
        check_eq("rst_addr", qpi_addr, 0);
        check_eq("rst_fill_data", fill_data, 0);
        check_eq("rst_wdata", qpi_wdata, 0);
    endtask

    task automatic run_line(input logic wr, input logic [AW-1:0] addr, input int stall,
                            input int hold, input int abort_at, input logic immediate);
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        int unsigned   start;
        int unsigned   idx;
        int unsigned   waited;
        logic [DW-1:0] d;
        fill_t         ent;
        base = addr - (addr % AW'(LW * STEP));
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
        start = (int'(addr) / STEP) % LW;
        a     = addr;
`else
        start = 0;
        a     = base;
`endif
        wb_rd_cnt = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (immediate) check_eq("accept_latency", waited, 0);
        if (!req_ready) begin
            check_eq("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        check_eq("accept_rd_en", wb_rd_en, wr);
        if (wr) check_eq("accept_rd_idx", wb_rd_idx, start);
        @(posedge clk); #1;
        req_valid   = 1'b0;
        qpi_is_idle = 1'b0;

        for (int k = 0; k < LW; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                @(posedge clk); #1;
                @(negedge clk);
                check_reset_outputs();
                @(posedge clk); #1;
                rst         = 1'b0;
                qpi_is_idle = 1'b1;
                check_eq("abort_fill_left", fill_q.size(), 0);
                check_eq("abort_done_left", done_q.size(), 0);
                last_addr = '0;
                return;
            end
            repeat (stall) begin
                @(posedge clk); #1;
            end
            idx = (start + k) % LW;
            d   = $urandom();
            qpi_next_word = 1'b1;
            qpi_rdata     = d;
            @(negedge clk);
            check_eq("qpi_addr", qpi_addr, a);
            check_eq("do_read", qpi_do_read, !wr && (k != LW - 1));
            check_eq("do_write", qpi_do_write, wr && (k != LW - 1));
            if (wr) begin
                check_eq("qpi_wdata", qpi_wdata, ram[idx]);
                check_eq("wb_rd_en", wb_rd_en, k != LW - 1);
                if (k != LW - 1) check_eq("wb_rd_idx", wb_rd_idx, (idx + 1) % LW);
            end else begin
                ent.idx  = IW'(idx);
                ent.data = d;
                fill_q.push_back(ent);
            end
            if (k == LW - 1) done_q.push_back(cyc + 1);
`ifdef QPI_LINE_ENGINE_CRITICAL_WORD_FIRST_EN
            a = (idx == LW - 1) ? base : a + AW'(STEP);
`else
            a = a + AW'(STEP);
`endif
            @(posedge clk); #1;
            qpi_next_word = 1'b0;
        end
        if (wr) check_eq("wb_rd_count", wb_rd_cnt, LW);

        // Adapter still busy: a pending request must be held off; strobes are stray.
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            if (h == 0) qpi_next_word = 1'b1;
            @(negedge clk);
            check_eq("drain_ready", req_ready, 0);
            check_eq("drain_rd_en", wb_rd_en, 0);
            @(posedge clk); #1;
            qpi_next_word = 1'b0;
        end
        qpi_is_idle = 1'b1;
        @(negedge clk);
        check_eq("drain_exit_ready", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("addr_after_line", qpi_addr, a);
        last_addr = a;
    endtask

    task automatic spurious_idle();
        qpi_next_word = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_fill_valid", fill_valid, 0);
            check_eq("idle_do_read", qpi_do_read, 0);
            check_eq("idle_addr", qpi_addr, last_addr);
        end
        @(posedge clk); #1;
        qpi_next_word = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        qpi_rdata     = '0;
        qpi_next_word = 1'b0;
        qpi_is_idle   = 1'b1;
        for (int i = 0; i < LW; i++) ram[i] = $urandom();

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        run_line(1'b0, 24'h000100, 0, 2, -1, 1'b0);
        spurious_idle();
        for (int i = 0; i < LW; i++) ram[i] = $urandom();
        run_line(1'b1, 24'h000200, 3, 0, -1, 1'b0);
        run_line(1'b0, 24'h000340, 1, 4, -1, 1'b0);
        run_line(1'b1, 24'h000400, 1, 1, -1, 1'b1);
        run_line(1'b0, 24'h000500, 0, 0, 3, 1'b0);
        run_line(1'b0, 24'h000500, 0, 1, -1, 1'b1);
        run_line(1'b0, 24'h00010A, 0, 1, -1, 1'b0);
        for (int i = 0; i < LW; i++) ram[i] = $urandom();
        run_line(1'b1, 24'hFFFFF0, 2, 0, -1, 1'b0);
        spurious_idle();

        repeat (4) @(posedge clk);
        check_eq("fill_q_empty", fill_q.size(), 0);
        check_eq("done_q_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
